// File: rtl/fpu_pkg.sv
// Shared FPU definitions: IEEE-754 single field widths, canonical constants,
// flag bit positions and the divider state encoding.
package fpu_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS   = 127;

  localparam logic [31:0] QNAN_CANON = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF    = 32'h7F80_0000;

  // flags = {invalid, div_by_zero, overflow, underflow, inexact}
  localparam int FLAG_INVALID   = 4;
  localparam int FLAG_DIV_ZERO  = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    NORM   = 2'd2,
    DONE   = 2'd3
  } div_state_e;

endpackage

// File: rtl/fp_div_round.sv
// Normalises the raw 26-bit quotient, rounds to nearest-even, applies the
// overflow/flush-to-zero limits and packs the single-precision result.
module fp_div_round
  import fpu_pkg::*;
(
  input  logic              sign,
  input  logic signed [9:0] e,
  input  logic [25:0]       q,
  input  logic              sticky,
  output logic [31:0]       result,
  output logic [4:0]        flags
);

  logic [23:0]       mant_s;
  logic              guard_s;
  logic              stk_s;
  logic              inc_s;
  logic [24:0]       sum_s;
  logic [22:0]       frac_s;
  logic signed [9:0] e_adj_s;
  logic signed [9:0] e_fin_s;

  // Normalise, round and range-check
  always_comb begin
    mant_s  = 24'd0;
    guard_s = 1'b0;
    stk_s   = 1'b0;
    e_adj_s = e;
    result  = 32'd0;
    flags   = 5'd0;
    // A quotient below 1.0 loses one integer bit, so shift up and drop the exponent
    if (q[25]) begin
      mant_s  = q[25:2];
      guard_s = q[1];
      stk_s   = q[0] | sticky;
      e_adj_s = e;
    end else begin
      mant_s  = q[24:1];
      guard_s = q[0];
      stk_s   = sticky;
      e_adj_s = e - 10'sd1;
    end
    inc_s = guard_s & (stk_s | mant_s[0]);
    sum_s = {1'b0, mant_s} + {24'd0, inc_s};
    if (sum_s[24]) begin
      frac_s  = sum_s[23:1];
      e_fin_s = e_adj_s + 10'sd1;
    end else begin
      frac_s  = sum_s[22:0];
      e_fin_s = e_adj_s;
    end
    if (e_fin_s >= 10'sd255) begin
      result                 = {sign, POS_INF[30:0]};
      flags[FLAG_OVERFLOW]   = 1'b1;
      flags[FLAG_INEXACT]    = 1'b1;
    end else if (e_fin_s <= 10'sd0) begin
      result                 = {sign, 31'd0};
      flags[FLAG_UNDERFLOW]  = 1'b1;
      flags[FLAG_INEXACT]    = 1'b1;
    end else begin
      result                 = {sign, e_fin_s[7:0], frac_s};
      flags[FLAG_INEXACT]    = guard_s | stk_s;
    end
  end

endmodule

// File: rtl/fp_divider.sv
// Sequential single-precision divider: radix-2 restoring mantissa division,
// one quotient bit per cycle, with valid/ready handshakes on both sides.
module fp_divider
  import fpu_pkg::*;
#(
  parameter logic [31:0] CANON_NAN = QNAN_CANON
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [4:0]  flags
);

  div_state_e        state_r, state_s;
  logic              in_ready_r;
  logic              out_valid_r;
  logic [31:0]       result_r;
  logic [4:0]        flags_r;
  logic [4:0]        count_r;
  logic [24:0]       rem_r;
  logic [23:0]       mb_r;
  logic [25:0]       q_r;
  logic signed [9:0] e_r;
  logic              sign_r;

  logic a_nan_s, a_inf_s, a_zero_s, b_nan_s, b_inf_s, b_zero_s;
  logic sign_s, special_s, accept_s;
  logic [31:0] spec_result_s, rnd_result_s;
  logic [4:0]  spec_flags_s, rnd_flags_s;

  // Denormals decode as zero
  assign a_nan_s  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
  assign a_inf_s  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
  assign a_zero_s = (a[30:23] == 8'h00);
  assign b_nan_s  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
  assign b_inf_s  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
  assign b_zero_s = (b[30:23] == 8'h00);
  assign sign_s    = a[31] ^ b[31];
  assign special_s = a_nan_s | a_inf_s | a_zero_s | b_nan_s | b_inf_s | b_zero_s;
  assign accept_s  = in_valid & in_ready_r;

  // Special-operand result selection, highest priority first
  always_comb begin
    spec_result_s = {sign_s, 31'd0};
    spec_flags_s  = 5'd0;
    if (a_nan_s || b_nan_s) begin
      spec_result_s = CANON_NAN;
    end else if ((a_inf_s && b_inf_s) || (a_zero_s && b_zero_s)) begin
      spec_result_s               = CANON_NAN;
      spec_flags_s[FLAG_INVALID]  = 1'b1;
    end else if (a_inf_s) begin
      spec_result_s = {sign_s, POS_INF[30:0]};
    end else if (b_zero_s) begin
      spec_result_s               = {sign_s, POS_INF[30:0]};
      spec_flags_s[FLAG_DIV_ZERO] = 1'b1;
    end else begin
      spec_result_s = {sign_s, 31'd0};
    end
  end

  fp_div_round u_round (
    .sign   (sign_r),
    .e      (e_r),
    .q      (q_r),
    .sticky (rem_r != 25'd0),
    .result (rnd_result_s),
    .flags  (rnd_flags_s)
  );

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (accept_s) state_s = special_s ? DONE : DIVIDE;
               else          state_s = IDLE;
      DIVIDE:  if (count_r == 5'd25) state_s = NORM;
               else                  state_s = DIVIDE;
      NORM:    state_s = DONE;
      DONE:    if (out_ready) state_s = IDLE;
               else           state_s = DONE;
      default: state_s = IDLE;
    endcase
  end

  // State register and the ready flag derived from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      in_ready_r <= 1'b1;
    end else begin
      state_r    <= state_s;
      in_ready_r <= (state_s == IDLE);
    end
  end

  // Operand capture, restoring division steps and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      result_r    <= 32'd0;
      flags_r     <= 5'd0;
      count_r     <= 5'd0;
      rem_r       <= 25'd0;
      mb_r        <= 24'd0;
      q_r         <= 26'd0;
      e_r         <= 10'sd0;
      sign_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: if (accept_s) begin
          sign_r  <= sign_s;
          e_r     <= $signed({2'b00, a[30:23]}) - $signed({2'b00, b[30:23]}) + 10'sd127;
          rem_r   <= {2'b01, a[22:0]};
          mb_r    <= {1'b1, b[22:0]};
          q_r     <= 26'd0;
          count_r <= 5'd0;
          if (special_s) begin
            result_r    <= spec_result_s;
            flags_r     <= spec_flags_s;
            out_valid_r <= 1'b1;
          end
        end
        DIVIDE: begin
          if (rem_r >= {1'b0, mb_r}) begin
            q_r   <= {q_r[24:0], 1'b1};
            rem_r <= (rem_r - {1'b0, mb_r}) << 1;
          end else begin
            q_r   <= {q_r[24:0], 1'b0};
            rem_r <= rem_r << 1;
          end
          count_r <= count_r + 5'd1;
        end
        NORM: begin
          result_r    <= rnd_result_s;
          flags_r     <= rnd_flags_s;
          out_valid_r <= 1'b1;
        end
        DONE: if (out_ready) out_valid_r <= 1'b0;
        default: out_valid_r <= 1'b0;
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign flags     = flags_r;

endmodule

// File: tb/tb_fp_divider.sv
// Randomised and directed bench for fp_divider against an exact-integer
// long-division reference of a/b with round-to-nearest-even.
module tb_fp_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic [4:0]  flags;

  int n_checks = 0;
  int n_fails  = 0;

  fp_divider dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact quotient via 64-bit integer division, then RNE
  task automatic ref_div(input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] r, output logic [4:0] f, output bit sp);
    int ex, ey, e, sh;
    bit xn, xi, xz, yn, yi, yz, sg, inex;
    longint unsigned n, qq, rr, low, half, mant, mb;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    xn = (ex == 255) && (x[22:0] != 23'd0);
    xi = (ex == 255) && (x[22:0] == 23'd0);
    xz = (ex == 0);
    yn = (ey == 255) && (y[22:0] != 23'd0);
    yi = (ey == 255) && (y[22:0] == 23'd0);
    yz = (ey == 0);
    sg = x[31] ^ y[31];
    sp = 1'b1;
    f  = 5'd0;
    r  = 32'd0;
    if (xn || yn) r = 32'h7FC0_0000;
    else if ((xi && yi) || (xz && yz)) begin r = 32'h7FC0_0000; f = 5'b10000; end
    else if (xi) r = {sg, 31'h7F80_0000};
    else if (yz) begin r = {sg, 31'h7F80_0000}; f = 5'b01000; end
    else if (xz || yi) r = {sg, 31'd0};
    else begin
      sp   = 1'b0;
      n    = longint'({1'b1, x[22:0]}) << 40;
      mb   = longint'({1'b1, y[22:0]});
      qq   = n / mb;
      rr   = n % mb;
      e    = ex - ey + 127;
      if (qq >= (64'd1 << 40)) sh = 17;
      else begin sh = 16; e = e - 1; end
      mant = qq >> sh;
      low  = qq & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      inex = (low != 0) || (rr != 0);
      if (low > half || (low == half && (rr != 0 || mant[0]))) mant = mant + 64'd1;
      if (mant == (64'd1 << 24)) begin mant = mant >> 1; e = e + 1; end
      if (e >= 255) begin r = {sg, 31'h7F80_0000}; f = 5'b00101; end
      else if (e <= 0) begin r = {sg, 31'd0}; f = 5'b00011; end
      else begin r = {sg, e[7:0], mant[22:0]}; f = {4'd0, inex}; end
    end
  endtask

  // One full transaction: accept, wait with garbage on the inputs, hold, handshake
  task automatic do_op(input logic [31:0] ta, input logic [31:0] tb2, input int hold, input string tag);
    logic [31:0] er;
    logic [4:0]  ef;
    bit sp, busy_ok;
    int k;
    ref_div(ta, tb2, er, ef, sp);
    @(negedge clk);
    check_eq($sformatf("%s_idle_ready", tag), {39'd0, in_ready}, 40'd1);
    a = ta; b = tb2; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    k = 0; busy_ok = 1'b1;
    while (!out_valid && k < 60) begin
      if (in_ready) busy_ok = 1'b0;
      @(negedge clk);
      a = $urandom; b = $urandom; in_valid = 1'b1; out_ready = 1'($urandom);
      @(posedge clk); #1;
      k++;
    end
    check_eq($sformatf("%s_latency", tag), 40'(k), sp ? 40'd0 : 40'd27);
    if (!sp) check_eq($sformatf("%s_busy_ready", tag), {39'd0, busy_ok}, 40'd1);
    check_eq($sformatf("%s_out", tag), {out_valid, in_ready, 1'b0, flags, result}, {1'b1, 1'b0, 1'b0, ef, er});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      a = $urandom; b = $urandom; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      check_eq($sformatf("%s_hold%0d", tag, i), {out_valid, in_ready, 1'b0, flags, result}, {1'b1, 1'b0, 1'b0, ef, er});
    end
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    check_eq($sformatf("%s_release", tag), {38'd0, out_valid, in_ready}, 40'd1);
    out_ready = 1'b0;
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 11))
      0:       v[30:0] = 31'd0;
      1:       v[30:0] = 31'h7F80_0000;
      2:       v[30:23] = 8'hFF;
      3:       v[30:23] = 8'h00;
      4:       v[30:23] = 8'($urandom_range(1, 4));
      5:       v[30:23] = 8'($urandom_range(250, 254));
      default: v[30:23] = 8'($urandom_range(1, 254));
    endcase
    return v;
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset", {in_ready, out_valid, 1'b0, flags, result}, {1'b1, 1'b0, 38'd0});
    @(negedge clk);
    rst_n = 1'b1;

    do_op(32'h40C0_0000, 32'h4000_0000, 0, "six_div_two");
    do_op(32'h3F80_0000, 32'h4040_0000, 0, "one_third");
    do_op(32'h3F80_0000, 32'h0000_0000, 0, "div_zero");
    do_op(32'h0000_0000, 32'h0000_0000, 0, "zero_zero");
    do_op(32'h7FC0_0001, $urandom, 0, "nan_in");
    do_op(32'h7F80_0000, 32'hFF80_0000, 0, "inf_inf");
    do_op(32'hFF80_0000, 32'h3F80_0000, 0, "inf_x");
    do_op(32'h4000_0000, 32'h7F80_0000, 0, "x_inf");
    do_op(32'h0012_3456, 32'h3F80_0000, 0, "denorm_a");
    do_op(32'h7F7F_FFFF, 32'h3F00_0000, 0, "overflow");
    do_op(32'h0080_0000, 32'h4000_0000, 0, "underflow");
    do_op(32'hC0C0_0000, 32'h4000_0000, 0, "neg");
    do_op(32'h3FFF_FFFF, 32'h3F80_0001, 0, "near_one");
    do_op(32'h40C0_0000, 32'h4000_0000, 10, "backpressure");

    // Asynchronous reset in the middle of the division
    @(negedge clk);
    a = 32'h40C0_0000; b = 32'h4000_0000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("async_reset", {in_ready, out_valid, 1'b0, flags, result}, {1'b1, 1'b0, 38'd0});
    @(negedge clk);
    rst_n = 1'b1;
    do_op(32'h40C0_0000, 32'h4000_0000, 0, "after_reset");

    for (int i = 0; i < 150; i++)
      do_op(rand_operand(), rand_operand(), int'($urandom_range(0, 2)), $sformatf("rand%0d", i));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
